// File: rtl/bus_pkg.sv
// bus_pkg: shared encodings for the memory-bus blocks
package bus_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_IO   = 1'b1;

    function automatic logic [1:0] onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester handshakes plus the shared memory port
interface mem_bus_arbiter_if;
    logic [1:0]  req, lock, rw, ack, err, gnt;
    logic [31:0] addr0, addr1, wdata0, wdata1, rdata;
    logic        mem_valid, mem_rw, mem_ready;
    logic [31:0] mem_address, mem_datao, mem_data;

    modport slave (
        input  req, lock, rw, addr0, addr1, wdata0, wdata1, mem_data, mem_ready,
        output ack, err, rdata, gnt, mem_valid, mem_rw, mem_address, mem_datao
    );

    modport master (
        output req, lock, rw, addr0, addr1, wdata0, wdata1, mem_data, mem_ready,
        input  ack, err, rdata, gnt, mem_valid, mem_rw, mem_address, mem_datao
    );
endinterface

// File: rtl/bus_timer.sv
// bus_timer: 8-bit saturating wait counter flagging the TIMEOUT-th enabled cycle
module bus_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);
    logic [7:0] cnt;

    // Count enabled cycles since the last clear, sticking at all-ones
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt <= 8'd0;
        else if (clr) cnt <= 8'd0;
        else if (en && cnt != 8'hff) cnt <= cnt + 8'd1;
    end

    // cnt holds the cycles already waited, so the current cycle is number cnt+1
    assign hit = en && ({1'b0, cnt} + 9'd1 >= 9'(TIMEOUT));
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin owner of the shared memory port with locked bursts and wait timeout
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 4,
    parameter int unsigned TIMEOUT  = 15
) (
    input logic              clock,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);
    state_t     state, state_n;
    logic       owner, owner_n, last, last_n, load, capture, hit;
    logic [7:0] burst, burst_n;

    bus_timer #(.TIMEOUT(TIMEOUT)) timer (
        .clock (clock),
        .reset (reset),
        .clr   (state != ISSUE),
        .en    (state == ISSUE),
        .hit   (hit)
    );

    // Arbitration and transfer sequencing; burst counts the grant being made, so a lock yields LOCK_MAX grants
    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        burst_n = burst;
        load    = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: if (|bus.req) begin
                owner_n = (bus.req == 2'b11) ? ~last : (bus.req[1] ? REQ_IO : REQ_CPU);
                burst_n = 8'd1;
                load    = 1'b1;
                state_n = ISSUE;
            end
            ISSUE: begin
                capture = bus.mem_ready;
                state_n = bus.mem_ready ? DONE : (hit ? ABORT : ISSUE);
            end
            DONE: begin
                last_n = owner;
                if (bus.lock[owner] && bus.req[owner] && burst < 8'(LOCK_MAX)) begin
                    burst_n = burst + 8'd1;
                    load    = 1'b1;
                    state_n = ISSUE;
                end else begin
                    burst_n = 8'd0;
                    state_n = IDLE;
                end
            end
            ABORT: begin
                last_n  = owner;
                burst_n = 8'd0;
                state_n = IDLE;
            end
        endcase
    end

    // State, round-robin pointer, burst count and the latched memory-side fields
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            owner           <= REQ_CPU;
            last            <= REQ_IO;
            burst           <= 8'd0;
            bus.mem_address <= 32'd0;
            bus.mem_datao   <= 32'd0;
            bus.mem_rw      <= RW_READ;
            bus.rdata       <= 32'd0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
            burst <= burst_n;
            if (load) begin
                bus.mem_address <= owner_n ? bus.addr1 : bus.addr0;
                bus.mem_datao   <= owner_n ? bus.wdata1 : bus.wdata0;
                bus.mem_rw      <= bus.rw[owner_n];
            end
            if (capture && bus.mem_rw == RW_READ) bus.rdata <= bus.mem_data;
        end
    end

    assign bus.mem_valid = state == ISSUE;
    assign bus.gnt       = (state == IDLE) ? 2'b00 : onehot(owner);
    assign bus.ack       = (state == DONE) ? onehot(owner) : 2'b00;
    assign bus.err       = (state == ABORT) ? onehot(owner) : 2'b00;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random and directed traffic against a transfer-timeline model with a completion scoreboard
module tb_mem_bus_arbiter;
    localparam int TO = 15;
    localparam int LM = 4;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    mem_bus_arbiter_if bus ();
    mem_bus_arbiter #(.LOCK_MAX(LM), .TIMEOUT(TO)) dut (.clock(clock), .reset(rst_n), .bus(bus));

    typedef struct {
        int          cyc;
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem[16];
    int          checks = 0, failures = 0, cyc = 0;
    int          force_d = -1, ready_cyc = -1;
    logic [1:0]  done_seen = 2'b00, auto_en = 2'b00, keep = 2'b00, early = 2'b00, lock_rand = 2'b00;

    bit          m_busy, m_ok;
    logic        m_own, m_last, m_rw;
    int          m_burst, m_start, m_end, m_free;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // A new transfer occupies the port from cycle t+1; its outcome is decided here by the memory's chosen delay
    task automatic start_issue(input int t);
        int   r, d;
        exp_t e;
        r = $urandom_range(99);
        d = force_d >= 0 ? force_d : r < 60 ? $urandom_range(2) : r < 85 ? $urandom_range(TO - 1) : r < 92 ? TO - 1 : 99;
        m_addr  = m_own ? bus.addr1 : bus.addr0;
        m_wdata = m_own ? bus.wdata1 : bus.wdata0;
        m_rw    = bus.rw[m_own];
        m_start = t + 1;
        m_ok    = d < TO;
        m_end   = m_ok ? m_start + d : m_start + TO - 1;
        ready_cyc = m_ok ? m_start + d : -1;
        if (m_ok && m_rw) m_rdata = mem[m_addr[5:2]];
        e.cyc   = m_end + 1;
        e.ack   = m_ok ? 2'b01 << m_own : 2'b00;
        e.err   = m_ok ? 2'b00 : 2'b01 << m_own;
        e.rdata = m_rdata;
        q.push_back(e);
    endtask

    // Reference model: who owns the port when, and what the memory side must show each cycle
    always @(negedge clock) begin
        if (!rst_n) begin
            m_busy = 0; m_last = 1'b1; m_burst = 0; m_free = 0; ready_cyc = -1;
            m_addr = 0; m_wdata = 0; m_rw = 1'b1; m_rdata = 0;
            q.delete();
        end else begin
            check("mem_valid", 32'(bus.mem_valid), 32'(m_busy && cyc >= m_start && cyc <= m_end));
            check("gnt", 32'(bus.gnt), (m_busy && cyc >= m_start && cyc <= m_end + 1) ? 32'(2'b01 << m_own) : 32'd0);
            check("mem_address", bus.mem_address, m_addr);
            check("mem_datao", bus.mem_datao, m_wdata);
            check("mem_rw", 32'(bus.mem_rw), 32'(m_rw));
            if (m_busy && cyc == m_end + 1) begin
                m_last = m_own;
                if (m_ok && !m_rw) mem[m_addr[5:2]] = m_wdata;
                if (m_ok && bus.lock[m_own] && bus.req[m_own] && m_burst < LM) begin
                    m_burst++;
                    start_issue(cyc);
                end else begin
                    m_busy = 0; m_burst = 0; m_free = cyc + 1;
                end
            end else if (!m_busy && cyc >= m_free && bus.req != 2'b00) begin
                m_own = (bus.req == 2'b11) ? !m_last : bus.req[1];
                m_busy = 1; m_burst = 1;
                start_issue(cyc);
            end
        end
    end

    // Scoreboard monitor: every ack/err pulse must match the oldest expected completion
    always @(negedge clock) begin
        exp_t e;
        if (!rst_n) begin
            check("rst_gnt", 32'(bus.gnt), 0);
            check("rst_ack", 32'(bus.ack), 0);
            check("rst_err", 32'(bus.err), 0);
            check("rst_mem_valid", 32'(bus.mem_valid), 0);
            check("rst_mem_rw", 32'(bus.mem_rw), 1);
            check("rst_mem_address", bus.mem_address, 0);
            check("rst_mem_datao", bus.mem_datao, 0);
            check("rst_rdata", bus.rdata, 0);
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL missing_done cycle %0d: got none expected completion at cycle %0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (bus.ack != 2'b00 || bus.err != 2'b00) begin
                done_seen = done_seen | bus.ack | bus.err;
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done cycle %0d: got ack=%b err=%b expected none", cyc, bus.ack, bus.err);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("ack", 32'(bus.ack), 32'(e.ack));
                    check("err", 32'(bus.err), 32'(e.err));
                    check("rdata", bus.rdata, e.rdata);
                end
            end
        end
    end

    task automatic new_txn(input int p);
        logic [31:0] a;
        a = {26'd0, 4'($urandom_range(15)), 2'b00};
        if (p == 1) begin bus.addr1 = a; bus.wdata1 = $urandom; end
        else begin bus.addr0 = a; bus.wdata0 = $urandom; end
        bus.rw[p] = 1'($urandom_range(1));
        if (lock_rand[p]) bus.lock[p] = ($urandom_range(3) == 0);
    endtask

    task automatic raise(input int p, input logic r, input logic [31:0] a, input logic [31:0] w);
        if (p == 1) begin bus.addr1 = a; bus.wdata1 = w; end
        else begin bus.addr0 = a; bus.wdata0 = w; end
        bus.rw[p]  = r;
        bus.req[p] = 1'b1;
    endtask

    // One clock of requester and memory behaviour, driven just after the rising edge
    task automatic step();
        @(posedge clock);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (bus.req[p] && done_seen[p]) begin
                if (keep[p]) new_txn(p);
                else bus.req[p] = 1'b0;
            end else if (bus.req[p] && early[p]) begin
                bus.req[p] = 1'b0;
                early[p] = 1'b0;
            end else if (!bus.req[p] && auto_en[p] && $urandom_range(3) == 0) begin
                new_txn(p);
                bus.req[p] = 1'b1;
            end
            done_seen[p] = 1'b0;
        end
        bus.mem_ready = (cyc == ready_cyc);
        bus.mem_data  = mem[bus.mem_address[5:2]];
    endtask

    initial begin
        bus.req = 0; bus.lock = 0; bus.rw = 0; bus.addr0 = 0; bus.addr1 = 0;
        bus.wdata0 = 0; bus.wdata1 = 0; bus.mem_ready = 0; bus.mem_data = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[4] = 32'hDEADBEEF;
        repeat (3) step();
        rst_n = 1'b1;
        // single CPU read answered on the first ISSUE cycle
        force_d = 0;
        raise(0, 1'b1, 32'h10, 32'h0);
        repeat (6) step();
        // both requesting continuously, no lock: strict alternation
        keep = 2'b11;
        new_txn(0); bus.req[0] = 1'b1;
        new_txn(1); bus.req[1] = 1'b1;
        repeat (18) step();
        keep = 2'b00;
        repeat (10) step();
        // port 0 locked while port 1 waits
        bus.lock = 2'b01; keep = 2'b11;
        new_txn(0); bus.req[0] = 1'b1;
        new_txn(1); bus.req[1] = 1'b1;
        repeat (30) step();
        keep = 2'b00; bus.lock = 2'b00;
        repeat (15) step();
        // memory never ready: timeout abort
        force_d = 99;
        raise(0, 1'b1, 32'h20, 32'h0);
        repeat (20) step();
        // ready on the very cycle the timeout would fire
        force_d = TO - 1;
        raise(0, 1'b1, 32'h10, 32'h0);
        repeat (20) step();
        // I/O write whose request drops during ISSUE
        force_d = 1;
        raise(1, 1'b0, 32'h8, 32'h1234);
        early[1] = 1'b1;
        repeat (6) step();
        // reset while a transfer is in ISSUE
        force_d = 10;
        raise(0, 1'b1, 32'h10, 32'h0);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("reset_drops_valid", 32'(bus.mem_valid), 0);
        check("reset_drops_gnt", 32'(bus.gnt), 0);
        bus.req = 2'b00; done_seen = 2'b00; force_d = -1;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) step();
        // randomized traffic with random locks, delays and timeouts
        auto_en = 2'b11; lock_rand = 2'b11;
        repeat (20) begin
            keep = 2'($urandom_range(3));
            repeat (100) step();
        end
        auto_en = 2'b00; keep = 2'b00; lock_rand = 2'b00; bus.lock = 2'b00;
        repeat (80) step();
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
